uart_fifo_sync_param: RTL and testbench

// - Parametrised single-clock FIFO for the UART TX/RX data paths; successor to the fixed 128x8 FIFO controller.
// - Generic width/depth; true full at DEPTH entries; programmable threshold flag; occupancy count.
// - Optional first-word-fall-through (FWFT) read; sticky overflow/underflow error flags; synchronous flush.
// - Sits between the APB register interface and the UART TX/RX shift logic; all ports are on the system clock.

---
 rtl/uart_fifo_pkg.sv | 19 +
 rtl/uart_fifo_ram_sdp.sv | 30 +++
 rtl/uart_fifo_sync_param.sv | 144 ++++++++++++++
 tb/tb_uart_fifo_sync_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART FIFO family.
package uart_fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Usable in parameter context to size pointers from DEPTH.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on the array.
module uart_fifo_ram_sdp
    import uart_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 128,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the old word when both ports hit the same address.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_fifo_sync_param.sv
// Parametrised single-clock FIFO for the UART data paths: count, flags, sticky errors,
// flush, and optional first-word-fall-through read.
module uart_fifo_sync_param
    import uart_fifo_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 128,
    parameter  int FWFT       = 0,
    parameter  int SYNC_RESET = 0,
    localparam int AW         = clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [CW-1:0]    level,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             half,
    output logic             overflow,
    output logic             underflow
);

    logic             arst_n;
    logic             srst;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_set;
    logic             unf_set;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_q;
    logic             byp_hit;
    logic             byp_sel;
    logic [WIDTH-1:0] byp_data;
    logic             loaded;

    assign arst_n = (SYNC_RESET != 0) ? 1'b1 : reset_n;
    assign srst   = (SYNC_RESET != 0) && !reset_n;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign half  = (count_q >= level);
    assign count = count_q;

    // A read on an empty FIFO freezes everything, including a same-cycle write.
    assign rd_acc  = !read_n && !empty && !flush;
    assign wr_acc  = !write_n && !flush && !(!read_n && empty) && (!full || rd_acc);
    assign ovf_set = !write_n && !flush && full && !rd_acc;
    assign unf_set = !read_n && !flush && empty;

    assign rd_ptr_nxt = rd_acc ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // FWFT keeps the head prefetched; a write landing on the new head bypasses the RAM.
    always_comb begin
        ram_rd_en = 1'b0;
        ram_addr  = rd_ptr;
        byp_hit   = 1'b0;
        if (FWFT == FIFO_MODE_FWFT) begin
            ram_rd_en = !flush && (count_nxt != '0);
            ram_addr  = rd_ptr_nxt;
            byp_hit   = wr_acc && (wr_ptr == rd_ptr_nxt);
        end else begin
            ram_rd_en = rd_acc;
        end
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (srst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count_q   <= count_nxt;
            overflow  <= ovf_set || (overflow && !clr_err);
            underflow <= unf_set || (underflow && !clr_err);
        end
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            loaded   <= 1'b0;
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else if (srst) begin
            loaded   <= 1'b0;
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else if (ram_rd_en) begin
            loaded   <= 1'b1;
            byp_sel  <= byp_hit;
            byp_data <= data_in;
        end
    end

    // Until the first load the RAM output is undefined, so present zero.
    assign data_out = !loaded ? '0 : (byp_sel ? byp_data : ram_q);

    uart_fifo_ram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc && reset_n),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (ram_rd_en && reset_n),
        .rd_addr (ram_addr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_uart_fifo_sync_param.sv
// Directed bench: registered-read FIFO at DEPTH=128 and a small FWFT FIFO at DEPTH=4.
module tb_uart_fifo_sync_param;

    logic       clock;
    logic       reset_n;

    logic       flush0, write_n0, read_n0, clr_err0;
    logic [7:0] data_in0, data_out0, level0, count0;
    logic       full0, empty0, half0, overflow0, underflow0;

    logic       flush1, write_n1, read_n1, clr_err1;
    logic [7:0] data_in1, data_out1;
    logic [2:0] level1, count1;
    logic       full1, empty1, half1, overflow1, underflow1;

    int checks   = 0;
    int failures = 0;
    int exp_val;

    uart_fifo_sync_param #(.WIDTH(8), .DEPTH(128), .FWFT(0), .SYNC_RESET(0)) dut_reg (
        .clock(clock), .reset_n(reset_n), .flush(flush0), .data_in(data_in0),
        .write_n(write_n0), .read_n(read_n0), .level(level0), .clr_err(clr_err0),
        .data_out(data_out0), .count(count0), .full(full0), .empty(empty0),
        .half(half0), .overflow(overflow0), .underflow(underflow0)
    );

    uart_fifo_sync_param #(.WIDTH(8), .DEPTH(4), .FWFT(1), .SYNC_RESET(0)) dut_fwft (
        .clock(clock), .reset_n(reset_n), .flush(flush1), .data_in(data_in1),
        .write_n(write_n1), .read_n(read_n1), .level(level1), .clr_err(clr_err1),
        .data_out(data_out1), .count(count1), .full(full1), .empty(empty1),
        .half(half1), .overflow(overflow1), .underflow(underflow1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        flush0   = 1'b0; write_n0 = 1'b1; read_n0 = 1'b1; clr_err0 = 1'b0;
        data_in0 = 8'h00; level0 = 8'd64;
        flush1   = 1'b0; write_n1 = 1'b1; read_n1 = 1'b1; clr_err1 = 1'b0;
        data_in1 = 8'h00; level1 = 3'd2;
        tick();
        tick();
        check("rst_count", count0, 0);
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_data", data_out0, 0);
        check("rst_ovf", overflow0, 0);
        check("rst_unf", underflow0, 0);
        check("rst_fwft_data", data_out1, 0);
        check("rst_fwft_empty", empty1, 1);
        reset_n = 1'b1;
        tick();

        // fill to full, half threshold crossing at 64
        for (int i = 1; i <= 128; i++) begin
            data_in0 = 8'(i);
            write_n0 = 1'b0;
            tick();
            if (i == 63) check("half_63", half0, 0);
            if (i == 64) check("half_64", half0, 1);
        end
        check("fill_full", full0, 1);
        check("fill_count", count0, 128);
        data_in0 = 8'hFF;
        tick();
        write_n0 = 1'b1;
        check("ovf_set", overflow0, 1);
        check("ovf_count", count0, 128);
        clr_err0 = 1'b1;
        tick();
        clr_err0 = 1'b0;
        check("ovf_clr", overflow0, 0);

        // drain in order, one cycle read latency
        read_n0 = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            tick();
            check("drain_data", data_out0, i);
        end
        check("drain_empty", empty0, 1);
        tick();
        read_n0 = 1'b1;
        check("unf_set", underflow0, 1);
        check("unf_hold_data", data_out0, 8'h80);
        check("unf_count", count0, 0);
        clr_err0 = 1'b1;
        tick();
        clr_err0 = 1'b0;
        check("unf_clr", underflow0, 0);

        // read+write on empty: underflow, write dropped
        read_n0  = 1'b0;
        write_n0 = 1'b0;
        data_in0 = 8'h55;
        tick();
        read_n0  = 1'b1;
        write_n0 = 1'b1;
        check("rw_empty_unf", underflow0, 1);
        check("rw_empty_count", count0, 0);
        level0 = 8'd0;
        #1;
        check("half_level0", half0, 1);
        level0 = 8'd64;

        for (int i = 1; i <= 128; i++) begin
            data_in0 = 8'(i);
            write_n0 = 1'b0;
            tick();
        end
        write_n0 = 1'b1;
        level0 = 8'd129;
        #1;
        check("half_level129", half0, 0);
        level0 = 8'd64;

        // simultaneous read+write while full
        for (int k = 0; k < 10; k++) begin
            read_n0  = 1'b0;
            write_n0 = 1'b0;
            data_in0 = 8'(8'h81 + k);
            tick();
            check("rw_full_data", data_out0, k + 1);
        end
        read_n0  = 1'b1;
        write_n0 = 1'b1;
        check("rw_full_count", count0, 128);
        check("rw_full_ovf", overflow0, 0);

        read_n0 = 1'b0;
        for (int i = 0; i < 128; i++) begin
            tick();
            exp_val = (i < 118) ? (11 + i) : (8'h81 + i - 118);
            check("wrap_data", data_out0, exp_val);
        end
        read_n0 = 1'b1;
        check("wrap_empty", empty0, 1);

        // flush with a sticky underflow pending; data_out must hold
        read_n0 = 1'b0;
        tick();
        read_n0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in0 = 8'(8'h40 + i);
            write_n0 = 1'b0;
            tick();
        end
        flush0   = 1'b1;
        read_n0  = 1'b0;
        data_in0 = 8'hEE;
        tick();
        flush0   = 1'b0;
        write_n0 = 1'b1;
        read_n0  = 1'b1;
        check("flush_count", count0, 0);
        check("flush_empty", empty0, 1);
        check("flush_half", half0, 0);
        check("flush_unf", underflow0, 0);
        check("flush_ovf", overflow0, 0);
        check("flush_data", data_out0, 8'h8A);

        // asynchronous reset mid-burst
        for (int i = 0; i < 37; i++) begin
            data_in0 = 8'(8'h20 + i);
            write_n0 = 1'b0;
            tick();
        end
        check("burst_count", count0, 37);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", count0, 0);
        check("arst_empty", empty0, 1);
        check("arst_data", data_out0, 0);
        write_n0 = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        data_in0 = 8'hC3;
        write_n0 = 1'b0;
        tick();
        write_n0 = 1'b1;
        check("post_rst_count", count0, 1);
        read_n0 = 1'b0;
        tick();
        read_n0 = 1'b1;
        check("post_rst_data", data_out0, 8'hC3);
        check("post_rst_empty", empty0, 1);

        // FWFT instance
        data_in1 = 8'hA5;
        write_n1 = 1'b0;
        tick();
        write_n1 = 1'b1;
        check("fwft_a5_data", data_out1, 8'hA5);
        check("fwft_a5_empty", empty1, 0);
        read_n1 = 1'b0;
        tick();
        read_n1 = 1'b1;
        check("fwft_rd_empty", empty1, 1);
        check("fwft_rd_hold", data_out1, 8'hA5);
        for (int i = 1; i <= 4; i++) begin
            data_in1 = 8'(i);
            write_n1 = 1'b0;
            tick();
            check("fwft_head", data_out1, 1);
        end
        write_n1 = 1'b1;
        check("fwft_full", full1, 1);
        read_n1  = 1'b0;
        write_n1 = 1'b0;
        data_in1 = 8'h05;
        tick();
        write_n1 = 1'b1;
        check("fwft_rw_data", data_out1, 2);
        check("fwft_rw_count", count1, 4);
        for (int i = 3; i <= 5; i++) begin
            tick();
            check("fwft_drain", data_out1, i);
        end
        tick();
        read_n1 = 1'b1;
        check("fwft_drain_empty", empty1, 1);
        check("fwft_drain_hold", data_out1, 5);
        read_n1  = 1'b0;
        write_n1 = 1'b0;
        data_in1 = 8'h77;
        tick();
        check("fwft_rw_empty_unf", underflow1, 1);
        check("fwft_rw_empty_count", count1, 0);
        read_n1  = 1'b1;
        data_in1 = 8'h11;
        tick();
        check("fwft_one_data", data_out1, 8'h11);
        read_n1  = 1'b0;
        data_in1 = 8'h22;
        tick();
        read_n1  = 1'b1;
        write_n1 = 1'b1;
        check("fwft_bypass_data", data_out1, 8'h22);
        check("fwft_bypass_count", count1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
